// File: rtl/rule110_pkg.sv
// Shared definitions for the Rule 110 generation core and its seed loader.
// Holds the default array width, the loader state encoding and the power-on seed.
package rule110_pkg;

    localparam int RULE110_WIDTH = 256;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Single live cell at bit 0; the core can run from this without any loaded bytes.
    localparam logic [RULE110_WIDTH-1:0] RULE110_DEFAULT_SEED = RULE110_WIDTH'(1);

endpackage

// File: rtl/rule110_seed_loader_if.sv
// Byte-in / seed-out bus of the Rule 110 seed loader.
// The master side feeds bytes and consumes seeds; the slave side is the loader.
interface rule110_seed_loader_if
    import rule110_pkg::*;
#(
    parameter int WIDTH = RULE110_WIDTH
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [7:0]       byte_in;
    logic             byte_vld;
    logic [WIDTH-1:0] seed_out;
    logic             seed_valid;
    logic             seed_ready;
    logic [CNT_W-1:0] fill_cnt;
    logic             overflow;

    modport master (
        output byte_in, byte_vld, seed_ready,
        input  seed_out, seed_valid, fill_cnt, overflow
    );

    modport slave (
        input  byte_in, byte_vld, seed_ready,
        output seed_out, seed_valid, fill_cnt, overflow
    );

endinterface

// File: rtl/rule110_seed_shreg.sv
// WIDTH-bit byte-wide shift register with load enable and synchronous clear.
// Clear together with load restarts the register with the incoming byte as byte 0.
module rule110_seed_shreg #(
    parameter int               WIDTH     = 256,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= load ? WIDTH'(byte_in) : '0;
        end else if (load) begin
            q <= {q[WIDTH-9:0], byte_in};
        end
    end

endmodule

// File: rtl/rule110_seed_loader.sv
// Assembles a WIDTH-bit seed from strobed bytes and offers it on a valid/ready handshake.
// Define RULE110_SEED_DEFAULT_EN to come out of reset already holding the default seed.
module rule110_seed_loader
    import rule110_pkg::*;
#(
    parameter int WIDTH = RULE110_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clr,
    rule110_seed_loader_if.slave   bus
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

`ifdef RULE110_SEED_DEFAULT_EN
    localparam loader_state_t    RST_STATE = FULL;
    localparam logic             RST_VALID = 1'b1;
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(NBYTES);
    localparam logic [WIDTH-1:0] RST_SEED  = WIDTH'(RULE110_DEFAULT_SEED);
`else
    localparam loader_state_t    RST_STATE = FILL;
    localparam logic             RST_VALID = 1'b0;
    localparam logic [CNT_W-1:0] RST_CNT   = '0;
    localparam logic [WIDTH-1:0] RST_SEED  = '0;
`endif

    loader_state_t    state;
    logic             seed_valid;
    logic [CNT_W-1:0] fill_cnt;
    logic             overflow;
    logic [WIDTH-1:0] seed;

    logic byte_hit;
    logic handshake;
    logic accept;
    logic last_byte;

    assign byte_hit  = ena & bus.byte_vld;
    assign handshake = seed_valid & bus.seed_ready;
    // A byte arriving on the handshake edge is captured as byte 0 of the next seed.
    assign accept    = byte_hit & ((state == FILL) | handshake);
    assign last_byte = (fill_cnt == CNT_W'(NBYTES - 1));

    rule110_seed_shreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RST_SEED)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr | handshake),
        .load    (accept & ~clr),
        .byte_in (bus.byte_in),
        .q       (seed)
    );

    // NOTE: the asynchronous reset branch must assign every register in the block, or the flops infer a hold path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            seed_valid <= RST_VALID;
            fill_cnt   <= RST_CNT;
            overflow   <= 1'b0;
        end else if (clr) begin
            state      <= FILL;
            seed_valid <= 1'b0;
            fill_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (last_byte) begin
                            state      <= FULL;
                            seed_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (handshake) begin
                        state      <= FILL;
                        seed_valid <= 1'b0;
                        fill_cnt   <= accept ? CNT_W'(1) : '0;
                    end else if (byte_hit) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state      <= FILL;
                    seed_valid <= 1'b0;
                    fill_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.seed_out   = seed;
    assign bus.seed_valid = seed_valid;
    assign bus.fill_cnt   = fill_cnt;
    assign bus.overflow   = overflow;

endmodule

// File: tb/tb_rule110_seed_loader.sv
// Self-checking bench for rule110_seed_loader: directed scenarios plus randomized traffic
// compared against a byte-queue reference model.
module tb_rule110_seed_loader;

    localparam int WIDTH  = 256;
    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    rule110_seed_loader_if #(.WIDTH(WIDTH)) bus ();

    rule110_seed_loader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: the bytes of the current seed in arrival order.
    logic [7:0] m_bytes[$];
    bit         m_full;
    bit         m_ovf;

    function automatic logic [WIDTH-1:0] exp_seed();
        logic [WIDTH-1:0] s = '0;
        foreach (m_bytes[i]) s = (s << 8) | WIDTH'(m_bytes[i]);
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt();
        return CNT_W'(m_bytes.size());
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_ovf = 0;
`ifdef RULE110_SEED_DEFAULT_EN
        for (int i = 0; i < NBYTES - 1; i++) m_bytes.push_back(8'h00);
        m_bytes.push_back(8'h01);
        m_full = 1;
`else
        m_full = 0;
`endif
    endtask

    task automatic model_step(input bit e, input bit v, input logic [7:0] b, input bit r, input bit c);
        if (c) begin
            m_bytes.delete();
            m_full = 0;
            m_ovf  = 0;
        end else if (m_full) begin
            if (r) begin
                m_bytes.delete();
                m_full = 0;
                if (e && v) m_bytes.push_back(b);
            end else if (e && v) begin
                m_ovf = 1;
            end
        end else if (e && v) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == NBYTES) m_full = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic drive_cycle(input bit e, input bit v, input logic [7:0] b, input bit r, input bit c);
        ena            = e;
        bus.byte_vld   = v;
        bus.byte_in    = b;
        bus.seed_ready = r;
        clr            = c;
        model_step(e, v, b, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ena = 0; clr = 0;
        bus.byte_vld = 0; bus.byte_in = '0; bus.seed_ready = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (bus.seed_valid !== m_full || bus.fill_cnt !== exp_cnt() || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%0b cnt=%0d ovf=%0b, want valid=%0b cnt=%0d ovf=0",
                     bus.seed_valid, bus.fill_cnt, bus.overflow, m_full, exp_cnt());
        end
        n_tests++;
        if (bus.seed_out !== exp_seed()) begin
            n_fail++;
            $display("FAIL reset_seed: got %h want %h", bus.seed_out, exp_seed());
        end
`ifdef RULE110_SEED_DEFAULT_EN
        n_tests++;
        if (bus.seed_out !== WIDTH'(1)) begin
            n_fail++;
            $display("FAIL reset_default_seed: got %h want 1", bus.seed_out);
        end
        drive_cycle(0, 0, 8'h00, 1, 0);
        n_tests++;
        if (bus.seed_valid !== 1'b0 || bus.fill_cnt !== '0) begin
            n_fail++;
            $display("FAIL default_handshake: got valid=%0b cnt=%0d want valid=0 cnt=0",
                     bus.seed_valid, bus.fill_cnt);
        end
`endif
    endtask

    task automatic test_fill();
        for (int k = 1; k <= NBYTES; k++) begin
            drive_cycle(1, 1, 8'(k), 0, 0);
            if (k == NBYTES - 1) begin
                n_tests++;
                if (bus.seed_valid !== 1'b0 || bus.fill_cnt !== CNT_W'(NBYTES - 1)) begin
                    n_fail++;
                    $display("FAIL fill_early_valid: got valid=%0b cnt=%0d want valid=0 cnt=%0d",
                             bus.seed_valid, bus.fill_cnt, NBYTES - 1);
                end
            end
        end
        n_tests++;
        if (bus.seed_valid !== 1'b1 || bus.fill_cnt !== CNT_W'(NBYTES)) begin
            n_fail++;
            $display("FAIL fill_done: got valid=%0b cnt=%0d want valid=1 cnt=%0d",
                     bus.seed_valid, bus.fill_cnt, NBYTES);
        end
        n_tests++;
        if (bus.seed_out[WIDTH-1 -: 8] !== 8'h01 || bus.seed_out[7:0] !== 8'h20) begin
            n_fail++;
            $display("FAIL fill_order: got msb=%h lsb=%h want msb=01 lsb=20",
                     bus.seed_out[WIDTH-1 -: 8], bus.seed_out[7:0]);
        end
        n_tests++;
        if (bus.seed_out !== exp_seed()) begin
            n_fail++;
            $display("FAIL fill_seed: got %h want %h", bus.seed_out, exp_seed());
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) drive_cycle(1, 1, 8'($urandom), 0, 0);
        n_tests++;
        if (bus.seed_out !== exp_seed() || bus.seed_valid !== 1'b1 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got valid=%0b ovf=%0b seed=%h want valid=1 ovf=1 seed=%h",
                     bus.seed_valid, bus.overflow, bus.seed_out, exp_seed());
        end
        drive_cycle(1, 1, 8'h55, 1, 1);
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.seed_valid !== 1'b0 || bus.fill_cnt !== '0 || bus.seed_out !== '0) begin
            n_fail++;
            $display("FAIL overflow_clr: got ovf=%0b valid=%0b cnt=%0d seed=%h want all zero",
                     bus.overflow, bus.seed_valid, bus.fill_cnt, bus.seed_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int k = 1; k <= 2 * NBYTES; k++) begin
            b = (k == NBYTES + 1) ? 8'hAA : 8'($urandom);
            if (k == NBYTES + 1) begin
                n_tests++;
                if (bus.seed_valid !== 1'b1 || bus.seed_out !== exp_seed()) begin
                    n_fail++;
                    $display("FAIL b2b_seed1: got valid=%0b seed=%h want valid=1 seed=%h",
                             bus.seed_valid, bus.seed_out, exp_seed());
                end
            end
            drive_cycle(1, 1, b, 1, 0);
            if (k == NBYTES + 1) begin
                n_tests++;
                if (bus.seed_valid !== 1'b0 || bus.fill_cnt !== CNT_W'(1) || bus.seed_out !== WIDTH'(8'hAA)) begin
                    n_fail++;
                    $display("FAIL b2b_no_bubble: got valid=%0b cnt=%0d seed=%h want valid=0 cnt=1 seed=aa",
                             bus.seed_valid, bus.fill_cnt, bus.seed_out);
                end
            end
        end
        n_tests++;
        if (bus.seed_valid !== 1'b1 || bus.seed_out[WIDTH-1 -: 8] !== 8'hAA ||
            bus.overflow !== 1'b0 || bus.seed_out !== exp_seed()) begin
            n_fail++;
            $display("FAIL b2b_seed2: got valid=%0b ovf=%0b seed=%h want valid=1 ovf=0 seed=%h",
                     bus.seed_valid, bus.overflow, bus.seed_out, exp_seed());
        end
        drive_cycle(0, 0, 8'h00, 1, 0);
        n_tests++;
        if (bus.seed_valid !== 1'b0 || bus.fill_cnt !== '0 || bus.seed_out !== '0) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid=%0b cnt=%0d seed=%h want valid=0 cnt=0 seed=0",
                     bus.seed_valid, bus.fill_cnt, bus.seed_out);
        end
    endtask

    task automatic test_ena_gap();
        for (int k = 1; k <= NBYTES + 6; k++) begin
            drive_cycle(!(k >= 10 && k <= 15), 1, 8'(k), 0, 0);
            if (k == 15) begin
                n_tests++;
                if (bus.fill_cnt !== CNT_W'(9)) begin
                    n_fail++;
                    $display("FAIL ena_hold: got cnt=%0d want 9", bus.fill_cnt);
                end
            end
        end
        n_tests++;
        if (bus.seed_valid !== 1'b1 || bus.seed_out !== exp_seed() || bus.seed_out[7:0] !== 8'(NBYTES + 6)) begin
            n_fail++;
            $display("FAIL ena_resume: got valid=%0b seed=%h want valid=1 seed=%h",
                     bus.seed_valid, bus.seed_out, exp_seed());
        end
        drive_cycle(0, 0, 8'h00, 0, 1);
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 17; k++) drive_cycle(1, 1, 8'($urandom), 0, 0);
        n_tests++;
        if (bus.fill_cnt !== CNT_W'(17)) begin
            n_fail++;
            $display("FAIL async_prefill: got cnt=%0d want 17", bus.fill_cnt);
        end
        ena = 0;
        bus.byte_vld = 0;
        #3;
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (bus.seed_valid !== m_full || bus.fill_cnt !== exp_cnt() ||
            bus.overflow !== 1'b0 || bus.seed_out !== exp_seed()) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b cnt=%0d ovf=%0b seed=%h want valid=%0b cnt=%0d ovf=0 seed=%h",
                     bus.seed_valid, bus.fill_cnt, bus.overflow, bus.seed_out, m_full, exp_cnt(), exp_seed());
        end
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit e, v, r, c;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e = ($urandom % 8) != 0;
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) == 0;
            c = ($urandom % 64) == 0;
            drive_cycle(e, v, 8'($urandom), r, c);
            n_tests++;
            if ({bus.seed_valid, bus.fill_cnt, bus.overflow, bus.seed_out} !==
                {m_full, exp_cnt(), m_ovf, exp_seed()}) begin
                n_fail++;
                $display("FAIL random_c%0d: got valid=%0b cnt=%0d ovf=%0b seed=%h want valid=%0b cnt=%0d ovf=%0b seed=%h",
                         cyc, bus.seed_valid, bus.fill_cnt, bus.overflow, bus.seed_out,
                         m_full, exp_cnt(), m_ovf, exp_seed());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_ena_gap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
